// File: rtl/comp_event_ctrl.sv
// Comparator event qualifier: N-sample zone qualification, sticky W1C trip flags, registered IRQ.
// Optional overflow tracking is built when COMP_EVT_OVF_EN is defined; otherwise evt_ovf_out is 2'b00.
module comp_event_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             SYSCLK,
  input  logic             SYSRST,
  input  logic             comp_en_reg,
  input  logic             comp_osr_signal,
  input  logic             comp_low_signal,
  input  logic             comp_high_signal,
  input  logic [CNT_W-1:0] evt_cnt_reg,
  input  logic [1:0]       evt_ie_reg,
  input  logic [1:0]       evt_clr,
  output logic [1:0]       evt_flag_out,
  output logic [1:0]       evt_zone_out,
  output logic [1:0]       evt_ovf_out,
  output logic             evt_irq
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INRANGE   = 3'd1;
  localparam logic [2:0] LOW_Q     = 3'd2;
  localparam logic [2:0] HIGH_Q    = 3'd3;
  localparam logic [2:0] LOW_TRIP  = 3'd4;
  localparam logic [2:0] HIGH_TRIP = 3'd5;

  logic [2:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc, cnt_sel, n_eff;
  logic [1:0]       trip_entry;
  logic [1:0]       flag_next;

  // A programmed count of zero behaves as a single-sample qualification.
  assign n_eff   = (evt_cnt_reg == '0) ? CNT_W'(1) : evt_cnt_reg;
  assign cnt_inc = (cnt < n_eff) ? cnt + CNT_W'(1) : cnt;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cnt_sel    = '0;
    if (!comp_en_reg) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state == IDLE) begin
      state_next = INRANGE;
    end else if (comp_osr_signal) begin
      if (comp_high_signal) begin
        if (state != HIGH_TRIP) begin
          cnt_sel    = (state == HIGH_Q) ? cnt_inc : CNT_W'(1);
          cnt_next   = cnt_sel;
          state_next = (cnt_sel >= n_eff) ? HIGH_TRIP : HIGH_Q;
        end
      end else if (comp_low_signal) begin
        if (state != LOW_TRIP) begin
          cnt_sel    = (state == LOW_Q) ? cnt_inc : CNT_W'(1);
          cnt_next   = cnt_sel;
          state_next = (cnt_sel >= n_eff) ? LOW_TRIP : LOW_Q;
        end
      end else begin
        state_next = INRANGE;
        cnt_next   = '0;
      end
    end
  end

  // Flags are set only on the transition into a trip state, never per sample.
  assign trip_entry[0] = (state_next == LOW_TRIP)  && (state != LOW_TRIP);
  assign trip_entry[1] = (state_next == HIGH_TRIP) && (state != HIGH_TRIP);
  assign flag_next     = (evt_flag_out & ~evt_clr) | trip_entry;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state        <= IDLE;
      cnt          <= '0;
      evt_flag_out <= 2'b00;
      evt_irq      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      evt_flag_out <= flag_next;
      evt_irq      <= |(evt_flag_out & evt_ie_reg);
    end
  end

  assign evt_zone_out = (state == LOW_TRIP)  ? 2'b01 :
                        (state == HIGH_TRIP) ? 2'b10 : 2'b00;

`ifdef COMP_EVT_OVF_EN
  logic [1:0] ovf_set;

  // A repeat trip counts as overflow only if its flag survives this cycle's clear.
  assign ovf_set = trip_entry & evt_flag_out & ~evt_clr;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      evt_ovf_out <= 2'b00;
    end else begin
      evt_ovf_out <= (evt_ovf_out & ~evt_clr) | ovf_set;
    end
  end
`else
  assign evt_ovf_out = 2'b00;
`endif

endmodule

// File: tb/tb_comp_event_ctrl.sv
// Directed bench for comp_event_ctrl: qualification, trip flags, W1C, IRQ latency, reset/disable.
// Overflow expectations follow COMP_EVT_OVF_EN.
module tb_comp_event_ctrl;

  logic       SYSCLK = 1'b0;
  logic       SYSRST;
  logic       comp_en_reg;
  logic       comp_osr_signal;
  logic       comp_low_signal;
  logic       comp_high_signal;
  logic [3:0] evt_cnt_reg;
  logic [1:0] evt_ie_reg;
  logic [1:0] evt_clr;
  logic [1:0] evt_flag_out;
  logic [1:0] evt_zone_out;
  logic [1:0] evt_ovf_out;
  logic       evt_irq;

  int vectors = 0;
  int miscompares = 0;

`ifdef COMP_EVT_OVF_EN
  localparam logic [1:0] OVF_RETRIP = 2'b01;
`else
  localparam logic [1:0] OVF_RETRIP = 2'b00;
`endif

  comp_event_ctrl #(.CNT_W(4)) dut (
    .SYSCLK           (SYSCLK),
    .SYSRST           (SYSRST),
    .comp_en_reg      (comp_en_reg),
    .comp_osr_signal  (comp_osr_signal),
    .comp_low_signal  (comp_low_signal),
    .comp_high_signal (comp_high_signal),
    .evt_cnt_reg      (evt_cnt_reg),
    .evt_ie_reg       (evt_ie_reg),
    .evt_clr          (evt_clr),
    .evt_flag_out     (evt_flag_out),
    .evt_zone_out     (evt_zone_out),
    .evt_ovf_out      (evt_ovf_out),
    .evt_irq          (evt_irq)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  // One decimated sample: strobe plus zone inputs for a single cycle.
  task automatic applyStimulus(input logic low, input logic high);
    comp_osr_signal  = 1'b1;
    comp_low_signal  = low;
    comp_high_signal = high;
    tick();
    comp_osr_signal  = 1'b0;
    comp_low_signal  = 1'b0;
    comp_high_signal = 1'b0;
  endtask

  task automatic clearFlags(input logic [1:0] bits);
    evt_clr = bits;
    tick();
    evt_clr = 2'b00;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    SYSRST           = 1'b1;
    comp_en_reg      = 1'($urandom);
    comp_osr_signal  = 1'($urandom);
    comp_low_signal  = 1'($urandom);
    comp_high_signal = 1'($urandom);
    evt_cnt_reg      = 4'($urandom);
    evt_ie_reg       = 2'($urandom);
    evt_clr          = 2'($urandom);
    tick();
    tick();
    checkOutput("rst_flag", evt_flag_out, 2'b00);
    checkOutput("rst_zone", evt_zone_out, 2'b00);
    checkOutput("rst_ovf",  evt_ovf_out,  2'b00);
    checkOutput("rst_irq",  {1'b0, evt_irq}, 2'b00);

    comp_en_reg      = 1'b0;
    comp_osr_signal  = 1'b0;
    comp_low_signal  = 1'b0;
    comp_high_signal = 1'b0;
    evt_cnt_reg      = 4'd1;
    evt_ie_reg       = 2'b11;
    evt_clr          = 2'b00;
    SYSRST           = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_ignores_sample", evt_flag_out, 2'b00);
    tick();
    checkOutput("idle_irq", {1'b0, evt_irq}, 2'b00);

    // N=3 low qualification and IRQ latency
    comp_en_reg = 1'b1;
    tick();
    evt_cnt_reg = 4'd3;
    evt_ie_reg  = 2'b01;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_two_low_flag", evt_flag_out, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_trip_flag", evt_flag_out, 2'b01);
    checkOutput("t2_trip_zone", evt_zone_out, 2'b01);
    checkOutput("t2_irq_not_yet", {1'b0, evt_irq}, 2'b00);
    tick();
    checkOutput("t2_irq", {1'b0, evt_irq}, 2'b01);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_back_inrange", evt_zone_out, 2'b00);
    clearFlags(2'b01);
    checkOutput("t2_clr_flag", evt_flag_out, 2'b00);
    checkOutput("t2_irq_held", {1'b0, evt_irq}, 2'b01);
    tick();
    checkOutput("t2_irq_drop", {1'b0, evt_irq}, 2'b00);

    // Interrupted qualification restarts the count
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_flag", evt_flag_out, 2'b00);
    checkOutput("t3_zone", evt_zone_out, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_cnt2_flag", evt_flag_out, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_cnt3_flag", evt_flag_out, 2'b01);

    // N=1, high wins, direct trip-to-trip
    evt_cnt_reg = 4'd1;
    evt_ie_reg  = 2'b00;
    clearFlags(2'b01);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_high_zone", evt_zone_out, 2'b10);
    checkOutput("t5_high_flag", evt_flag_out, 2'b10);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_low_zone", evt_zone_out, 2'b01);
    checkOutput("t5_low_flag", evt_flag_out, 2'b11);

    // Set beats clear on simultaneous high trip entry
    evt_ie_reg = 2'b10;
    tick();
    checkOutput("t4_irq_before", {1'b0, evt_irq}, 2'b01);
    evt_clr = 2'b10;
    applyStimulus(1'b0, 1'b1);
    evt_clr = 2'b00;
    checkOutput("t4_flag_kept", evt_flag_out, 2'b11);
    checkOutput("t4_zone", evt_zone_out, 2'b10);
    checkOutput("t4_no_ovf", evt_ovf_out, 2'b00);
    tick();
    checkOutput("t4_irq_kept", {1'b0, evt_irq}, 2'b01);
    evt_ie_reg = 2'b00;
    tick();
    checkOutput("ie_off_irq", {1'b0, evt_irq}, 2'b00);
    clearFlags(2'b11);
    checkOutput("clr_both", evt_flag_out, 2'b00);

    // N=0 behaves as N=1
    evt_cnt_reg = 4'd0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("n0_zone", evt_zone_out, 2'b01);
    checkOutput("n0_flag", evt_flag_out, 2'b01);
    clearFlags(2'b01);

    // N=2: saturation in trip, then crossing to high
    evt_cnt_reg = 4'd2;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat_cnt1_zone", evt_zone_out, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat_trip_zone", evt_zone_out, 2'b01);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("sat_hold_zone", evt_zone_out, 2'b01);
    applyStimulus(1'b0, 1'b1);
    checkOutput("cross_highq_zone", evt_zone_out, 2'b00);
    applyStimulus(1'b0, 1'b1);
    checkOutput("cross_hightrip_zone", evt_zone_out, 2'b10);
    checkOutput("cross_flag", evt_flag_out, 2'b11);
    clearFlags(2'b11);

    // Lowering N mid-qualification trips on the next strobe
    evt_cnt_reg = 4'd5;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("nchg_before", evt_zone_out, 2'b00);
    evt_cnt_reg = 4'd2;
    applyStimulus(1'b1, 1'b0);
    checkOutput("nchg_zone", evt_zone_out, 2'b01);
    checkOutput("nchg_flag", evt_flag_out, 2'b01);

    // Disable forces idle but keeps flags
    comp_en_reg = 1'b0;
    tick();
    checkOutput("dis_zone", evt_zone_out, 2'b00);
    checkOutput("dis_flag_kept", evt_flag_out, 2'b01);
    comp_en_reg = 1'b1;
    tick();
    evt_cnt_reg = 4'd3;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre_rst_zone", evt_zone_out, 2'b00);

    // Async reset mid-qualification
    SYSRST = 1'b1;
    #2;
    checkOutput("async_rst_flag", evt_flag_out, 2'b00);
    checkOutput("async_rst_zone", evt_zone_out, 2'b00);
    SYSRST = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_no_partial", evt_flag_out, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_trip", evt_flag_out, 2'b01);

    // Re-trip with flag still set
    evt_cnt_reg = 4'd2;
    clearFlags(2'b01);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_first_flag", evt_flag_out, 2'b01);
    checkOutput("t6_first_ovf", evt_ovf_out, 2'b00);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_retrip_ovf", evt_ovf_out, OVF_RETRIP);
    clearFlags(2'b01);
    checkOutput("t6_clr_flag", evt_flag_out, 2'b00);
    checkOutput("t6_clr_ovf", evt_ovf_out, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
